// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the seven-segment display formatter.
// Holds the digit-code field positions, the dash glyph, the largest
// displayable decimal value and the formatter FSM state type.
package sevenseg_pkg;

  // Digit code layout: bit6 = enable, bit5 = decimal point, bits4:0 = glyph.
  localparam int SEG_EN = 6;
  localparam int SEG_DP = 5;

  localparam logic [4:0] GLY_DASH = 5'h10;

  // Largest value that fits in eight decimal digits.
  localparam logic [31:0] MAX_DEC = 32'd99_999_999;

  localparam int NUM_DIG = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_LOAD,
    ST_OVF
  } state_e;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble nibble correction: adds 3 to a BCD nibble of 5 or more so
// that the following left shift carries correctly into the next decade.
//   nib_i : BCD nibble before correction
//   nib_o : corrected nibble
module bcd_adj3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bcd_disp_fmt.sv
// Binary-to-decimal formatter for an eight-digit seven-segment controller.
// Accepts an unsigned value over a valid/ready handshake, converts it to
// eight BCD digits with one double-dabble step per cycle, then applies
// leading-zero blanking and decimal-point placement. The digit codes are
// held until the next conversion finishes.
//   clk, rst      : clock, asynchronous active-high reset
//   valid_in      : request; value/dp_en/dp_pos valid while high
//   ready         : high in IDLE; transfer on valid_in && ready
//   value         : unsigned binary value (W bits)
//   dp_en, dp_pos : decimal point enable and digit index (0 = rightmost)
//   done          : one-cycle pulse when new digit codes appear
//   overflow      : set when the last accepted value exceeded 99_999_999
//   d7..d0        : digit codes {enable, dp, glyph[4:0]}
module bcd_disp_fmt
  import sevenseg_pkg::*;
#(
  parameter int W        = 27,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  output logic         ready,
  input  logic [W-1:0] value,
  input  logic         dp_en,
  input  logic [2:0]   dp_pos,
  output logic         done,
  output logic         overflow,
  output logic [6:0]   d7,
  output logic [6:0]   d6,
  output logic [6:0]   d5,
  output logic [6:0]   d4,
  output logic [6:0]   d3,
  output logic [6:0]   d2,
  output logic [6:0]   d1,
  output logic [6:0]   d0
);

  state_e                   state_q, state_d;
  logic [W-1:0]             bin_q, bin_d;
  logic [31:0]              bcd_q, bcd_d;
  logic [4:0]               cnt_q, cnt_d;
  logic                     dp_en_q, dp_en_d;
  logic [2:0]               dp_pos_q, dp_pos_d;
  logic [NUM_DIG-1:0][6:0]  dig_q, dig_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;

  logic [31:0]              bcd_adj;
  logic [31:0]              value_ext;
  logic [NUM_DIG-1:0][6:0]  fmt;

  // Corrected BCD register feeding the next shift.
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_adj
    bcd_adj3 u_adj (
      .nib_i (bcd_q[4*g +: 4]),
      .nib_o (bcd_adj[4*g +: 4])
    );
  end

  assign value_ext = {{(32-W){1'b0}}, value};

  // Formatted codes from the finished BCD register. Scanning from the most
  // significant digit, a digit stays blank while it and everything above it
  // is zero, unless it is at or right of the decimal-point digit.
  always_comb begin
    logic       zero_above;
    logic [2:0] dp_eff;
    logic [3:0] nib;
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    fmt        = '0;
    zero_above = 1'b1;
    dp_eff     = dp_en_q ? dp_pos_q : 3'd0;
    nib        = '0;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      nib        = bcd_q[4*i +: 4];
      zero_above = zero_above && (nib == 4'd0);
      fmt[i][SEG_EN]  = !(BLANK_LZ && zero_above && (3'(i) > dp_eff));
      fmt[i][SEG_DP]  = dp_en_q && (dp_pos_q == 3'(i));
      fmt[i][4:0]     = {1'b0, nib};
    end
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    dp_en_d  = dp_en_q;
    dp_pos_d = dp_pos_q;
    dig_d    = dig_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          dp_en_d  = dp_en;
          dp_pos_d = dp_pos;
          bin_d    = value;
          if (value_ext > MAX_DEC) begin
            state_d = ST_OVF;
          end else begin
            bcd_d   = '0;
            cnt_d   = 5'(W - 1);
            state_d = ST_CONV;
          end
        end
      end

      ST_CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        dig_d   = fmt;
        ovf_d   = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      ST_OVF: begin
        for (int i = 0; i < NUM_DIG; i++) begin
          dig_d[i]         = '0;
          dig_d[i][SEG_EN] = 1'b1;
          dig_d[i][4:0]    = GLY_DASH;
        end
        ovf_d   = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      dp_en_q  <= 1'b0;
      dp_pos_q <= '0;
      dig_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      dp_en_q  <= dp_en_d;
      dp_pos_q <= dp_pos_d;
      dig_q    <= dig_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign d7 = dig_q[7];
  assign d6 = dig_q[6];
  assign d5 = dig_q[5];
  assign d4 = dig_q[4];
  assign d3 = dig_q[3];
  assign d2 = dig_q[2];
  assign d1 = dig_q[1];
  assign d0 = dig_q[0];

endmodule

// File: tb/tb_bcd_disp_fmt.sv
// Self-checking bench for bcd_disp_fmt: directed cases plus randomized
// values compared against a decimal-arithmetic reference model.
module tb_bcd_disp_fmt;

  localparam int W = 27;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic         ready;
  logic [W-1:0] value;
  logic         dp_en;
  logic [2:0]   dp_pos;
  logic         done;
  logic         overflow;
  logic [6:0]   d7, d6, d5, d4, d3, d2, d1, d0;
  logic [55:0]  d_all;

  int total = 0;
  int bad   = 0;
  logic [55:0] prev_exp = '0;

  assign d_all = {d7, d6, d5, d4, d3, d2, d1, d0};

  always #5 clk = ~clk;

  bcd_disp_fmt #(.W(W), .BLANK_LZ(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .ready    (ready),
    .value    (value),
    .dp_en    (dp_en),
    .dp_pos   (dp_pos),
    .done     (done),
    .overflow (overflow),
    .d7 (d7), .d6 (d6), .d5 (d5), .d4 (d4),
    .d3 (d3), .d2 (d2), .d1 (d1), .d0 (d0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, then blanking and decimal point.
  function automatic logic [55:0] model(input longint v, input bit dpe, input int dpp);
    logic [55:0] r;
    int          dig [8];
    longint      t;
    bit          lead;
    int          dpeff;
    bit          en;
    r = '0;
    if (v > 64'd99_999_999) begin
      for (int i = 0; i < 8; i++) r[7*i +: 7] = 7'h50;
      return r;
    end
    t = v;
    for (int i = 0; i < 8; i++) begin
      dig[i] = int'(t % 10);
      t      = t / 10;
    end
    dpeff = dpe ? dpp : 0;
    lead  = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (dig[i] != 0) lead = 1'b0;
      en = !(lead && (i > dpeff));
      r[7*i +: 7] = {en, (dpe && dpp == i), 1'b0, 4'(dig[i])};
    end
    return r;
  endfunction

  task automatic run_txn(input logic [W-1:0] v, input bit dpe, input logic [2:0] dpp);
    logic [55:0] exp;
    bit          ovf_exp;
    int          lat;
    int          lat_exp;
    exp     = model(longint'(v), dpe, int'(dpp));
    ovf_exp = (longint'(v) > 64'd99_999_999);
    lat_exp = ovf_exp ? 1 : W + 1;
    @(negedge clk);
    check("ready_idle", ready, 1);
    valid_in = 1'b1;
    value    = v;
    dp_en    = dpe;
    dp_pos   = dpp;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    value    = W'($urandom);
    dp_en    = 1'($urandom);
    dp_pos   = 3'($urandom);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      check("hold", d_all, prev_exp);
      if (k == 1) check("ready_busy", ready, 0);
    end
    check("latency", lat, lat_exp);
    check("digits", d_all, exp);
    check("overflow", overflow, ovf_exp);
    check("ready_after", ready, 1);
    @(posedge clk);
    @(negedge clk);
    check("done_pulse", done, 0);
    prev_exp = exp;
  endtask

  initial begin
    int          done_cnt;
    int          xfers;
    int          dones;
    int          last;
    logic [55:0] pend_exp;
    logic [W-1:0] rv;

    rst      = 1'b1;
    valid_in = 1'b0;
    value    = '0;
    dp_en    = 1'b0;
    dp_pos   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_digits", d_all, 56'h0);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);

    // Directed cases.
    run_txn(W'(12345678), 1'b0, 3'd0);
    check("d_12345678_lit", d_all,
          {7'h41, 7'h42, 7'h43, 7'h44, 7'h45, 7'h46, 7'h47, 7'h48});
    run_txn(W'(42), 1'b0, 3'd0);
    check("d_42_lit", d_all, {42'h0, 7'h44, 7'h42});
    run_txn(W'(5), 1'b1, 3'd2);
    check("d_5dp_lit", d_all, {35'h0, 7'h60, 7'h40, 7'h45});

    // Reset in the middle of a conversion.
    @(negedge clk);
    valid_in = 1'b1;
    value    = W'(87654321);
    dp_en    = 1'b0;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_digits", d_all, 56'h0);
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    check("midrst_hold", d_all, 56'h0);
    prev_exp = '0;

    // Overflow, then recovery with zero.
    run_txn(W'(100_000_000), 1'b1, 3'd3);
    check("ovf_lit", d_all, {8{7'h50}});
    run_txn(W'(0), 1'b0, 3'd0);
    check("zero_lit", d_all, {49'h0, 7'h40});

    // valid_in held high with changing value: one transfer per W+2 cycles.
    xfers = 0;
    dones = 0;
    last  = -1;
    pend_exp = prev_exp;
    for (int c = 0; c <= 200; c++) begin
      @(negedge clk);
      if (done) begin
        check("cont_digits", d_all, pend_exp);
        dones++;
      end
      valid_in = (c <= 150);
      value    = W'($urandom_range(0, 99_999_999));
      dp_en    = 1'b0;
      dp_pos   = 3'd0;
      if (valid_in && ready) begin
        if (last >= 0) check("cont_spacing", c - last, W + 2);
        last     = c;
        pend_exp = model(longint'(value), 1'b0, 0);
        xfers++;
      end
    end
    valid_in = 1'b0;
    check("cont_xfers", xfers, 6);
    check("cont_dones", dones, 6);
    prev_exp = pend_exp;

    // Randomized values, dp settings and overflow cases.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       rv = W'($urandom_range(0, 999));
        1:       rv = W'($urandom_range(0, 99_999_999));
        2:       rv = W'($urandom_range(99_999_990, 100_000_010));
        default: rv = W'($urandom);
      endcase
      run_txn(rv, 1'($urandom), 3'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_disp_fmt.md
# bcd_disp_fmt

Sequential binary-to-decimal formatter that drives the eight 7-bit digit inputs (`d7`..`d0`) of the eight-digit seven-segment controller. It accepts an unsigned binary value through a valid/ready handshake and converts it to eight BCD digits by iterative double-dabble. It then applies leading-zero blanking and decimal-point placement, and holds the formatted digit codes until the next conversion completes.

## Interface
- `W`, 27: input value width, legal range 1..27.
- `BLANK_LZ`, 1: 1 blanks leading zeros; 0 shows all eight digits.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  request; `value`, `dp_en` and `dp_pos` are valid while it is high.
- `ready`  out  1  high only in IDLE; the transfer occurs on an edge where `valid_in && ready`.
- `value`  in  W  unsigned binary value to display.
- `dp_en`  in  1  enables the decimal point.
- `dp_pos`  in  3  digit index (0 = rightmost) that carries the decimal point.
- `done`  out  1  one-cycle pulse, coincident with the first cycle the new digit codes are visible.
- `overflow`  out  1  sticky flag; set when the last accepted value exceeded 99_999_999.
- `d7`..`d0`  out  7 each  digit codes: bit6 = enable, bit5 = decimal point, bits4:0 = glyph (0-15 hex, 16 = dash).

## Operation
- FSM states:
  - IDLE: `ready`=1; on a transfer, capture `value`, `dp_en`, `dp_pos`.
    - If value > 99_999_999, go to OVF.
    - Otherwise, clear the 32-bit BCD shift register, load the shift counter with W-1, and go to CONV.
  - CONV: one double-dabble step per cycle.
    - Add 3 to each BCD nibble ≥5.
    - Shift {bcd, bin} left by one.
    - Decrement the counter; after the W-th step go to LOAD.
  - LOAD: write all eight digit codes from the BCD register, clear `overflow`, pulse `done`, go to IDLE.
  - OVF: write all eight digits as glyph 16 (dash) with enable=1 and dp=0, set `overflow`, pulse `done`, go to IDLE.
- Leading-zero blanking (`BLANK_LZ`=1):
  - Digit i gets enable=0 if every digit j≥i is zero and i > dp_pos_eff.
  - dp_pos_eff = `dp_pos` if `dp_en`, otherwise 0.
  - Digit 0 is therefore always enabled, and the value 0 displays "0".
- Decimal point: digit `dp_pos` gets bit5=1 only when `dp_en`=1 and the state is not OVF.
- Busy behaviour: `valid_in` while busy is ignored and not queued. The digit outputs keep their previous codes throughout conversion, so there is no flicker.
- Reset: state IDLE, `ready`=1, `done`=0, `overflow`=0, all `d`=7'b0 (all digits blank). Reset mid-conversion discards the conversion.

## Timing
- Transfer at edge 0. CONV occupies edges 1..W. The LOAD edge is W+1, and new `d` values plus `done`=1 appear after edge W+1.
- For W=27, latency is 28 cycles from transfer to new digits.
- `ready` is low from after edge 0 until after edge W+1. A back-to-back transfer is possible at edge W+1 only if `ready` is sampled high. Since `ready` is not high at edge W+1, the earliest next transfer is edge W+2.
- OVF path: the transfer at edge 0 updates outputs after edge 1, with `done` high for that cycle.
- All outputs are registered, except `ready`, which is decoded from the state register.

## Structure
- Package `sevenseg_pkg` holds:
  - the digit-code bit positions (`SEG_EN`=6, `SEG_DP`=5);
  - the glyph constant `GLY_DASH`=5'h10;
  - the FSM state typedef;
  - the constant `MAX_DEC`=99_999_999.
- One combinational sub-module, `bcd_adj3`: 4-bit nibble in, nibble+3 if ≥5. Instantiate it 8 times in a generate loop.

## Test plan
- Reset mid-CONV: assert `rst` 5 cycles after a transfer → all `d`=0, `ready`=1, `done` never pulses.
- `value`=12345678, `dp_en`=0 → after 28 cycles:
  - `d7`..`d0` codes 0x41..0x48, i.e. enable plus glyphs 1..8;
  - `done` pulses once;
  - `overflow`=0.
- `value`=42, `dp_en`=0 → `d1`=0x44, `d0`=0x42, `d7`..`d2`=0x00.
- `value`=5, `dp_en`=1, `dp_pos`=2 → `d2`=0x60 ("0." with dp), `d1`=0x40, `d0`=0x45, `d7`..`d3` blank.
- `value`=100_000_000 → after 1 cycle all `d`=0x50, `overflow`=1. A following `value`=0 → `d0`=0x40, `overflow`=0.
- `valid_in` asserted continuously with changing `value` → exactly one transfer per 29 cycles, and intermediate values are ignored.
